// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC timebase core: status bit map, default widths
// and the alarm channel state record.
package rtc_pkg;

    localparam int unsigned RTC_ISTA_TICK      = 0;
    localparam int unsigned RTC_ISTA_OV        = 1;
    localparam int unsigned RTC_ISTA_ALRM_BASE = 2;

    localparam int unsigned RTC_CNT_WIDTH_DEF  = 32;
    localparam int unsigned RTC_PSCR_WIDTH_DEF = 20;
    localparam int unsigned RTC_ALRM_NUM_DEF   = 4;

    // Alarm channel state at the default counter width.
    typedef struct packed {
        logic [RTC_CNT_WIDTH_DEF-1:0] cmp;
        logic [RTC_CNT_WIDTH_DEF-1:0] per;
        logic                         armed;
    } rtc_chan_st_t;

endpackage

// File: rtl/rtc_alrm_core_if.sv
// Level/strobe bundle between the APB4 wrapper (master) and the RTC core (slave).
interface rtc_alrm_core_if
    import rtc_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = RTC_CNT_WIDTH_DEF,
    parameter int unsigned PSCR_WIDTH = RTC_PSCR_WIDTH_DEF,
    parameter int unsigned ALRM_NUM   = RTC_ALRM_NUM_DEF
);
    logic                    en_i;
    logic                    pscr_wr_i;
    logic [PSCR_WIDTH-1:0]   pscr_i;
    logic                    cnt_wr_i;
    logic [CNT_WIDTH-1:0]    cnt_wdata_i;
    logic [ALRM_NUM-1:0]     alrm_wr_i;
    logic [ALRM_NUM-1:0]     alrm_dis_i;
    logic [CNT_WIDTH-1:0]    alrm_cmp_i;
    logic [CNT_WIDTH-1:0]    alrm_per_i;
    logic [ALRM_NUM+1:0]     ie_i;
    logic [ALRM_NUM+1:0]     ista_clr_i;
    logic                    tick_o;
    logic [CNT_WIDTH-1:0]    cnt_o;
    logic [ALRM_NUM-1:0]     armed_o;
    logic [ALRM_NUM+1:0]     ista_o;
    logic                    irq_o;

    modport master (
        output en_i, pscr_wr_i, pscr_i, cnt_wr_i, cnt_wdata_i,
               alrm_wr_i, alrm_dis_i, alrm_cmp_i, alrm_per_i, ie_i, ista_clr_i,
        input  tick_o, cnt_o, armed_o, ista_o, irq_o
    );

    modport slave (
        input  en_i, pscr_wr_i, pscr_i, cnt_wr_i, cnt_wdata_i,
               alrm_wr_i, alrm_dis_i, alrm_cmp_i, alrm_per_i, ie_i, ista_clr_i,
        output tick_o, cnt_o, armed_o, ista_o, irq_o
    );

endinterface

// File: rtl/rtc_alrm_chan.sv
// One alarm channel: compare against the incremented counter, one-shot or
// auto-reload by adding the period to the compare value.
module rtc_alrm_chan
    import rtc_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = RTC_CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic [CNT_WIDTH-1:0] cnt_nxt,
    input  logic                 cnt_wr,
    input  logic                 wr,
    input  logic                 dis,
    input  logic [CNT_WIDTH-1:0] cmp,
    input  logic [CNT_WIDTH-1:0] per,
    output logic                 match_c,
    output logic                 armed
);

    typedef struct packed {
        logic [CNT_WIDTH-1:0] cmp;
        logic [CNT_WIDTH-1:0] per;
        logic                 armed;
    } chan_st_t;

    chan_st_t st_q;
    chan_st_t st_d;
    logic     hit;

    // A write in the match cycle replaces the channel and drops the event.
    always_comb begin
        st_d    = st_q;
        hit     = st_q.armed & tick & ~cnt_wr & (cnt_nxt == st_q.cmp);
        match_c = hit & ~wr;
        if (wr) begin
            st_d.cmp   = cmp;
            st_d.per   = per;
            st_d.armed = 1'b1;
        end else if (dis) begin
            st_d.armed = 1'b0;
        end else if (hit) begin
            if (st_q.per == '0) begin
                st_d.armed = 1'b0;
            end else begin
                st_d.cmp = st_q.cmp + st_q.per;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    assign armed = st_q.armed;

endmodule

// File: rtl/rtc_alrm_core.sv
// RTC timebase: prescaler, free-running time counter, alarm channels and
// sticky interrupt status.
module rtc_alrm_core
    import rtc_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = RTC_CNT_WIDTH_DEF,
    parameter int unsigned PSCR_WIDTH = RTC_PSCR_WIDTH_DEF,
    parameter int unsigned ALRM_NUM   = RTC_ALRM_NUM_DEF,
    parameter int unsigned PSCR_RST   = 0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    rtc_alrm_core_if.slave  bus
);

    localparam int unsigned ISTA_W = ALRM_NUM + 2;

    logic [PSCR_WIDTH-1:0] pre_q, pre_d;
    logic [PSCR_WIDTH-1:0] pscr_q, pscr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_nxt;
    logic [ISTA_W-1:0]     ista_q, ista_d, ista_set;
    logic [ALRM_NUM-1:0]   alrm_match;
    logic [ALRM_NUM-1:0]   armed;
    logic                  tick;
    logic                  ov;

    assign tick    = bus.en_i & (pre_q == pscr_q);
    assign cnt_nxt = cnt_q + CNT_WIDTH'(1);
    assign ov      = tick & ~bus.cnt_wr_i & (&cnt_q);

    // Next-state for prescaler, counter and status; counter load beats a tick.
    always_comb begin
        pre_d    = pre_q;
        pscr_d   = pscr_q;
        cnt_d    = cnt_q;
        ista_set = '0;

        if (bus.pscr_wr_i || bus.cnt_wr_i || tick) begin
            pre_d = '0;
        end else if (bus.en_i) begin
            pre_d = pre_q + PSCR_WIDTH'(1);
        end

        if (bus.pscr_wr_i) begin
            pscr_d = bus.pscr_i;
        end

        if (bus.cnt_wr_i) begin
            cnt_d = bus.cnt_wdata_i;
        end else if (tick) begin
            cnt_d = cnt_nxt;
        end

        ista_set[RTC_ISTA_TICK]                      = tick;
        ista_set[RTC_ISTA_OV]                        = ov;
        ista_set[RTC_ISTA_ALRM_BASE +: ALRM_NUM]     = alrm_match;
        ista_d = (ista_q & ~bus.ista_clr_i) | ista_set;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pre_q  <= '0;
            pscr_q <= PSCR_WIDTH'(PSCR_RST);
            cnt_q  <= '0;
            ista_q <= '0;
        end else begin
            pre_q  <= pre_d;
            pscr_q <= pscr_d;
            cnt_q  <= cnt_d;
            ista_q <= ista_d;
        end
    end

    for (genvar g = 0; g < int'(ALRM_NUM); g++) begin : g_chan
        rtc_alrm_chan #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_chan (
            .clk     (clk_i),
            .rst_n   (rst_n_i),
            .tick    (tick),
            .cnt_nxt (cnt_nxt),
            .cnt_wr  (bus.cnt_wr_i),
            .wr      (bus.alrm_wr_i[g]),
            .dis     (bus.alrm_dis_i[g]),
            .cmp     (bus.alrm_cmp_i),
            .per     (bus.alrm_per_i),
            .match_c (alrm_match[g]),
            .armed   (armed[g])
        );
    end

    assign bus.tick_o  = tick;
    assign bus.cnt_o   = cnt_q;
    assign bus.armed_o = armed;
    assign bus.ista_o  = ista_q;
    assign bus.irq_o   = |(ista_q & bus.ie_i);

endmodule

// File: tb/tb_rtc_alrm_core.sv
// Directed bench for rtc_alrm_core with an alarm-event scoreboard.
module tb_rtc_alrm_core;
    import rtc_pkg::*;

    localparam int unsigned CW = 32;
    localparam int unsigned PW = 20;
    localparam int unsigned AN = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [CW-1:0] exp_q[$];

    always #5 clk = ~clk;

    rtc_alrm_core_if #(.CNT_WIDTH(CW), .PSCR_WIDTH(PW), .ALRM_NUM(AN)) bus ();

    rtc_alrm_core #(
        .CNT_WIDTH  (CW),
        .PSCR_WIDTH (PW),
        .ALRM_NUM   (AN),
        .PSCR_RST   (0)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles; each alarm event on channel ch pops the scoreboard and must
    // coincide with the expected counter value.
    task automatic watch(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            bus.ista_clr_i = '0;
            if (bus.ista_o[RTC_ISTA_ALRM_BASE + ch]) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    failures++;
                    $error("FAIL alrm_extra ch=%0d observed_cnt=%0h expected=no_event", ch, bus.cnt_o);
                end
                if (exp_q.size() > 0) chk("alrm_cnt", 64'(bus.cnt_o), 64'(exp_q.pop_front()));
                bus.ista_clr_i[RTC_ISTA_ALRM_BASE + ch] = 1'b1;
            end
        end
        bus.ista_clr_i = '0;
        chk("alrm_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic idle_inputs();
        bus.pscr_wr_i  = 1'b0;
        bus.cnt_wr_i   = 1'b0;
        bus.alrm_wr_i  = '0;
        bus.alrm_dis_i = '0;
        bus.ista_clr_i = '0;
    endtask

    initial begin
        int nticks;
        bus.en_i = 1'b0; bus.pscr_i = '0; bus.cnt_wdata_i = '0;
        bus.alrm_cmp_i = '0; bus.alrm_per_i = '0; bus.ie_i = '0;
        idle_inputs();

        // Reset state
        step(); step();
        chk("rst_cnt", 64'(bus.cnt_o), 64'd0);
        chk("rst_armed", 64'(bus.armed_o), 64'd0);
        chk("rst_ista", 64'(bus.ista_o), 64'd0);
        chk("rst_irq", 64'(bus.irq_o), 64'd0);
        chk("rst_tick", 64'(bus.tick_o), 64'd0);
        rst_n = 1'b1;
        step();

        // Prescaler 3: tick every 4th cycle, cnt=5 twenty cycles after write
        bus.pscr_wr_i = 1'b1; bus.pscr_i = PW'(3);
        bus.cnt_wr_i = 1'b1; bus.cnt_wdata_i = '0;
        step();
        idle_inputs(); bus.en_i = 1'b1;
        chk("pre_tick_j0", 64'(bus.tick_o), 64'd0);
        nticks = 0;
        for (int j = 1; j <= 20; j++) begin
            step();
            if (bus.tick_o) nticks++;
            if (j == 3) chk("pre_first_tick", 64'(bus.tick_o), 64'd1);
        end
        chk("pre_tick_count", 64'(nticks), 64'd5);
        chk("pre_cnt20", 64'(bus.cnt_o), 64'd5);
        step();
        bus.pscr_wr_i = 1'b1; bus.pscr_i = PW'(3);
        step();
        idle_inputs();
        chk("pre_restart_j22", 64'(bus.tick_o), 64'd0);
        step();
        chk("pre_restart_j23", 64'(bus.tick_o), 64'd0);
        step(); step();
        chk("pre_restart_j25", 64'(bus.tick_o), 64'd1);

        // Overflow with prescaler 0
        bus.en_i = 1'b0; bus.pscr_wr_i = 1'b1; bus.pscr_i = '0;
        bus.cnt_wr_i = 1'b1; bus.cnt_wdata_i = 32'hFFFF_FFFE; bus.ista_clr_i = '1;
        step();
        idle_inputs(); bus.en_i = 1'b1;
        step();
        chk("ov_cnt_ff", 64'(bus.cnt_o), 64'hFFFF_FFFF);
        chk("ov_not_yet", 64'(bus.ista_o[RTC_ISTA_OV]), 64'd0);
        step();
        chk("ov_cnt_0", 64'(bus.cnt_o), 64'd0);
        chk("ov_set", 64'(bus.ista_o[RTC_ISTA_OV]), 64'd1);
        chk("ov_irq_masked", 64'(bus.irq_o), 64'd0);
        bus.ie_i = 6'b000010; bus.en_i = 1'b0;
        #1;
        chk("ov_irq_enabled", 64'(bus.irq_o), 64'd1);
        bus.ie_i = '0;

        // One-shot channel 0, cmp=10
        bus.cnt_wr_i = 1'b1; bus.cnt_wdata_i = '0; bus.ista_clr_i = '1;
        bus.alrm_wr_i = 4'b0001; bus.alrm_cmp_i = 32'd10; bus.alrm_per_i = '0;
        step();
        idle_inputs(); bus.en_i = 1'b1;
        chk("os_armed", 64'(bus.armed_o[0]), 64'd1);
        exp_q.push_back(32'd10);
        watch(0, 15);
        chk("os_disarmed", 64'(bus.armed_o[0]), 64'd0);
        bus.en_i = 1'b0; bus.cnt_wr_i = 1'b1; bus.cnt_wdata_i = 32'd5;
        step();
        idle_inputs(); bus.en_i = 1'b1;
        watch(0, 10);

        // Periodic channel 1, cmp=4 per=3
        bus.en_i = 1'b0; bus.cnt_wr_i = 1'b1; bus.cnt_wdata_i = '0; bus.ista_clr_i = '1;
        bus.alrm_wr_i = 4'b0010; bus.alrm_cmp_i = 32'd4; bus.alrm_per_i = 32'd3;
        step();
        idle_inputs(); bus.en_i = 1'b1;
        exp_q.push_back(32'd4); exp_q.push_back(32'd7);
        exp_q.push_back(32'd10); exp_q.push_back(32'd13);
        watch(1, 14);
        chk("per_armed", 64'(bus.armed_o[1]), 64'd1);
        bus.en_i = 1'b0; bus.cnt_wr_i = 1'b1; bus.cnt_wdata_i = 32'hFFFF_FFFC; bus.ista_clr_i = '1;
        bus.alrm_wr_i = 4'b0010; bus.alrm_cmp_i = 32'hFFFF_FFFE; bus.alrm_per_i = 32'd4;
        step();
        idle_inputs(); bus.en_i = 1'b1;
        exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'd2);
        watch(1, 7);
        bus.en_i = 1'b0; bus.alrm_dis_i = 4'b0010;
        step();
        idle_inputs();
        chk("per_dis", 64'(bus.armed_o[1]), 64'd0);

        // Collision: counter load on a matching tick
        bus.cnt_wr_i = 1'b1; bus.cnt_wdata_i = 32'd7; bus.ista_clr_i = '1;
        bus.alrm_wr_i = 4'b0100; bus.alrm_cmp_i = 32'd8; bus.alrm_per_i = '0;
        step();
        idle_inputs(); bus.en_i = 1'b1; bus.cnt_wr_i = 1'b1; bus.cnt_wdata_i = 32'd8;
        step();
        idle_inputs(); bus.en_i = 1'b0;
        chk("col_cntwr_cnt", 64'(bus.cnt_o), 64'd8);
        chk("col_cntwr_noevt", 64'(bus.ista_o[4]), 64'd0);
        chk("col_cntwr_armed", 64'(bus.armed_o[2]), 64'd1);

        // Collision: alarm write on a match cycle
        bus.cnt_wr_i = 1'b1; bus.cnt_wdata_i = 32'd7; bus.ista_clr_i = '1;
        step();
        idle_inputs(); bus.en_i = 1'b1;
        bus.alrm_wr_i = 4'b0100; bus.alrm_cmp_i = 32'd20; bus.alrm_per_i = '0;
        step();
        idle_inputs();
        chk("col_awr_cnt", 64'(bus.cnt_o), 64'd8);
        chk("col_awr_noevt", 64'(bus.ista_o[4]), 64'd0);
        exp_q.push_back(32'd20);
        watch(2, 12);
        chk("col_awr_oneshot", 64'(bus.armed_o[2]), 64'd0);

        // Collision: clear and set of the tick status in the same cycle
        bus.ista_clr_i = 6'b000001;
        step();
        idle_inputs();
        chk("col_clr_setwins", 64'(bus.ista_o[RTC_ISTA_TICK]), 64'd1);
        bus.en_i = 1'b0; bus.ista_clr_i = 6'b000001;
        step();
        idle_inputs();
        chk("col_clr_cleared", 64'(bus.ista_o[RTC_ISTA_TICK]), 64'd0);

        // Asynchronous reset mid-count
        bus.alrm_wr_i = 4'b1000; bus.alrm_cmp_i = 32'd1000; bus.alrm_per_i = '0; bus.ie_i = '1;
        step();
        idle_inputs(); bus.en_i = 1'b1;
        step(); step(); step();
        chk("pre_rst_armed", 64'(bus.armed_o[3]), 64'd1);
        chk("pre_rst_irq", 64'(bus.irq_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cnt", 64'(bus.cnt_o), 64'd0);
        chk("arst_armed", 64'(bus.armed_o), 64'd0);
        chk("arst_ista", 64'(bus.ista_o), 64'd0);
        chk("arst_irq", 64'(bus.irq_o), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
